// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the shared-ALU sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned FLAG_W = 4;

    // Flag bit positions inside resp_flags: {CarryOut, Zero, Overflow, Negative}
    localparam int unsigned CARRY = 3;
    localparam int unsigned ZERO  = 2;
    localparam int unsigned OVF   = 1;
    localparam int unsigned NEG   = 0;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 2'b00,
        ALU_XOR = 2'b01,
        ALU_SUB = 2'b10,
        ALU_SLT = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        DONE   = 2'b10
    } seq_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        alu_op_e           op;
    } alu_req_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin winner: the pointer breaks ties, a lone requester always wins.
module alu_rr_pick (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic ptr_i,
    output logic grant0_c_o,
    output logic grant1_c_o
);

    always_comb begin
        grant0_c_o = valid0_i && (!valid1_i || !ptr_i);
        grant1_c_o = valid1_i && (!valid0_i ||  ptr_i);
    end

endmodule

// File: rtl/alu_share_sequencer.sv
// Shares one slow combinational ALU between two requesters; operands are held
// on the ALU buses for a settle window before result and flags are captured.
module alu_share_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_result,
    output logic [FLAG_W-1:0] resp_flags,
    output logic              busy,

    output logic [DATA_W-1:0] alu_bus_a,
    output logic [DATA_W-1:0] alu_bus_b,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0] alu_output,
    input  logic              alu_carryout,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_negative
);

    // A zero settle window still needs one cycle of hold before capture.
    localparam int unsigned    SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);

    seq_state_e        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    alu_req_t          bus_q, bus_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              resp0_q, resp0_d;
    logic              resp1_q, resp1_d;
    logic              busy_q;

    logic              grant0_c, grant1_c;
    logic              accept0_c, accept1_c;
    alu_req_t          win_req_c;

    alu_rr_pick u_pick (
        .valid0_i   (req0_valid),
        .valid1_i   (req1_valid),
        .ptr_i      (ptr_q),
        .grant0_c_o (grant0_c),
        .grant1_c_o (grant1_c)
    );

    // Ready is offered only in IDLE and never while reset is held.
    always_comb begin
        req0_ready = reset_n && (state_q == IDLE) && grant0_c;
        req1_ready = reset_n && (state_q == IDLE) && grant1_c;
        accept0_c  = req0_valid && req0_ready;
        accept1_c  = req1_valid && req1_ready;
    end

    always_comb begin
        win_req_c = '{a: req0_a, b: req0_b, op: alu_op_e'(req0_op)};
        if (accept1_c) begin
            win_req_c = '{a: req1_a, b: req1_b, op: alu_op_e'(req1_op)};
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        bus_d    = bus_q;
        result_d = result_q;
        flags_d  = flags_q;
        resp0_d  = 1'b0;
        resp1_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept0_c || accept1_c) begin
                    bus_d   = win_req_c;
                    id_d    = accept1_c;
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    result_d        = alu_output;
                    flags_d[CARRY]  = alu_carryout;
                    flags_d[ZERO]   = alu_zero;
                    flags_d[OVF]    = alu_overflow;
                    flags_d[NEG]    = alu_negative;
                    resp0_d         = !id_q;
                    resp1_d         = id_q;
                    state_d         = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                ptr_d   = !id_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            id_q     <= 1'b0;
            cnt_q    <= '0;
            bus_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            resp0_q  <= 1'b0;
            resp1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            bus_q    <= bus_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            resp0_q  <= resp0_d;
            resp1_q  <= resp1_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    always_comb begin
        alu_bus_a   = bus_q.a;
        alu_bus_b   = bus_q.b;
        alu_ctrl    = bus_q.op;
        resp_result = result_q;
        resp_flags  = flags_q;
        resp0_valid = resp0_q;
        resp1_valid = resp1_q;
        busy        = busy_q;
    end

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Directed bench for alu_share_sequencer: a behavioural ALU model feeds two DUTs (S=4 and S=0).
module tb_alu_share_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic        rst_n;

    // DUT with S=4
    logic        r0v, r1v, r0rdy, r1rdy, rsp0, rsp1, bsy;
    logic [31:0] r0a, r0b, r1a, r1b, res, bus_a, bus_b, alu_out;
    logic [1:0]  r0op, r1op, ctrl;
    logic [3:0]  flg;
    logic        alu_c, alu_z, alu_v, alu_n;

    // DUT with S=0
    logic        z0v, z1v, z0rdy, z1rdy, zrsp0, zrsp1, zbsy;
    logic [31:0] z0a, z0b, z1a, z1b, zres, zbus_a, zbus_b, zalu_out;
    logic [1:0]  z0op, z1op, zctrl;
    logic [3:0]  zflg;
    logic        zalu_c, zalu_z, zalu_v, zalu_n;

    // Reference ALU: {carry, zero, ovf, neg, result}; carry on sub is the borrow.
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            2'b01: r = a ^ b;
            2'b10: begin
                r = a - b;
                c = (a < b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        return {c, (r == 32'd0), v, r[31], r};
    endfunction

    assign {alu_c, alu_z, alu_v, alu_n, alu_out}      = alu_model(bus_a, bus_b, ctrl);
    assign {zalu_c, zalu_z, zalu_v, zalu_n, zalu_out} = alu_model(zbus_a, zbus_b, zctrl);

    alu_share_sequencer #(.SETTLE_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .reset_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
        .req1_valid(r1v), .req1_ready(r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
        .resp0_valid(rsp0), .resp1_valid(rsp1), .resp_result(res), .resp_flags(flg),
        .busy(bsy), .alu_bus_a(bus_a), .alu_bus_b(bus_b), .alu_ctrl(ctrl),
        .alu_output(alu_out), .alu_carryout(alu_c), .alu_zero(alu_z),
        .alu_overflow(alu_v), .alu_negative(alu_n)
    );

    alu_share_sequencer #(.SETTLE_CYCLES(0), .CNT_W(4)) dut_s0 (
        .clk(clk), .reset_n(rst_n),
        .req0_valid(z0v), .req0_ready(z0rdy), .req0_a(z0a), .req0_b(z0b), .req0_op(z0op),
        .req1_valid(z1v), .req1_ready(z1rdy), .req1_a(z1a), .req1_b(z1b), .req1_op(z1op),
        .resp0_valid(zrsp0), .resp1_valid(zrsp1), .resp_result(zres), .resp_flags(zflg),
        .busy(zbsy), .alu_bus_a(zbus_a), .alu_bus_b(zbus_b), .alu_ctrl(zctrl),
        .alu_output(zalu_out), .alu_carryout(zalu_c), .alu_zero(zalu_z),
        .alu_overflow(zalu_v), .alu_negative(zalu_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation on the S=4 DUT: expect ready at T, response pulse at T+5.
    task automatic run_op(input string tag, input bit id, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [3:0] ef);
        int t0;
        bit got;
        @(posedge clk); #1;
        if (!id) begin r0v = 1'b1; r0a = a; r0b = b; r0op = op; end
        else     begin r1v = 1'b1; r1a = a; r1b = b; r1op = op; end
        @(negedge clk);
        chk({tag, "_ready"}, 32'(id ? r1rdy : r0rdy), 32'd1);
        t0 = cyc;
        @(posedge clk); #1;
        r0v = 1'b0; r1v = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (id ? rsp1 : rsp0) got = 1'b1;
        end
        chk({tag, "_latency"}, 32'(cyc - t0), 32'd5);
        chk({tag, "_other_resp"}, 32'(id ? rsp0 : rsp1), 32'd0);
        chk({tag, "_result"}, res, er);
        chk({tag, "_flags"}, 32'(flg), 32'(ef));
    endtask

    initial begin
        int  t0;
        int  tprev;
        int  pulses;
        bit  got;
        bit  both_seen;
        bit  gid;

        rst_n = 1'b0;
        r0v = 1'b1; r0a = 32'h1234; r0b = 32'h1; r0op = 2'b00;
        r1v = 1'b0; r1a = '0; r1b = '0; r1op = 2'b00;
        z0v = 1'b0; z0a = '0; z0b = '0; z0op = 2'b00;
        z1v = 1'b0; z1a = '0; z1b = '0; z1op = 2'b00;
        repeat (2) @(negedge clk);

        chk("rst_ready0", 32'(r0rdy), 32'd0);
        chk("rst_busy", 32'(bsy), 32'd0);
        chk("rst_bus_a", bus_a, 32'd0);
        chk("rst_ctrl", 32'(ctrl), 32'd0);
        chk("rst_result", res, 32'd0);
        chk("rst_flags", 32'(flg), 32'd0);
        chk("rst_resp", 32'({rsp0, rsp1}), 32'd0);
        r0v = 1'b0;
        rst_n = 1'b1;

        run_op("add", 1'b0, 2'b00, 32'd5, 32'd7, 32'd12, 4'b0000);
        run_op("sub_zero", 1'b1, 2'b10, 32'd3, 32'd3, 32'd0, 4'b0100);
        run_op("add_ovf", 1'b0, 2'b00, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0011);
        run_op("xor", 1'b1, 2'b01, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 4'b0000);
        run_op("slt", 1'b0, 2'b11, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000);

        repeat (3) @(negedge clk);
        chk("hold_bus_a", bus_a, 32'hFFFF_FFFF);
        chk("hold_result", res, 32'd1);
        chk("idle_busy", 32'(bsy), 32'd0);

        // Contention from a fresh reset: grants go 0,1,0 every 6 cycles.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        r0v = 1'b1; r0a = 32'd1; r0b = 32'd1; r0op = 2'b00;
        r1v = 1'b1; r1a = 32'd2; r1b = 32'd2; r1op = 2'b00;
        both_seen = 1'b0;
        tprev = 0;
        for (int g = 0; g < 3; g++) begin
            got = 1'b0;
            gid = 1'b0;
            for (int i = 0; i < 12 && !got; i++) begin
                @(negedge clk);
                if (r0rdy && r1rdy) both_seen = 1'b1;
                if (r0rdy || r1rdy) begin
                    got = 1'b1;
                    gid = r1rdy;
                end
            end
            chk($sformatf("cont_grant%0d_seen", g), 32'(got), 32'd1);
            chk($sformatf("cont_grant%0d_id", g), 32'(gid), 32'(g % 2));
            if (g > 0) chk($sformatf("cont_grant%0d_gap", g), 32'(cyc - tprev), 32'd6);
            tprev = cyc;
        end
        chk("cont_both_ready", 32'(both_seen), 32'd0);
        @(posedge clk); #1;
        r0v = 1'b0; r1v = 1'b0;
        repeat (8) @(negedge clk);
        chk("cont_last_result", res, 32'd2);

        // Reset two cycles into SETTLE: operation dropped, pointer back to req0.
        @(posedge clk); #1;
        r0v = 1'b1; r0a = 32'd9; r0b = 32'd9; r0op = 2'b00;
        @(negedge clk);
        chk("mid_rst_ready", 32'(r0rdy), 32'd1);
        @(posedge clk); #1;
        r0v = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bsy), 32'd0);
        chk("mid_rst_bus_a", bus_a, 32'd0);
        chk("mid_rst_bus_b", bus_b, 32'd0);
        chk("mid_rst_result", res, 32'd0);
        chk("mid_rst_flags", 32'(flg), 32'd0);
        chk("mid_rst_resp", 32'({rsp0, rsp1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp0 || rsp1) pulses++;
        end
        chk("mid_rst_no_pulse", 32'(pulses), 32'd0);
        @(posedge clk); #1;
        r0v = 1'b1; r1v = 1'b1;
        @(negedge clk);
        chk("post_rst_ready0", 32'(r0rdy), 32'd1);
        chk("post_rst_ready1", 32'(r1rdy), 32'd0);
        @(posedge clk); #1;
        r0v = 1'b0; r1v = 1'b0;
        repeat (8) @(negedge clk);

        // S=0 build behaves as S=1: response two cycles after acceptance.
        @(posedge clk); #1;
        z1v = 1'b1; z1a = 32'd10; z1b = 32'd20; z1op = 2'b00;
        @(negedge clk);
        chk("s0_ready", 32'(z1rdy), 32'd1);
        t0 = cyc;
        @(posedge clk); #1;
        z1v = 1'b0; z1a = 32'hDEAD_BEEF; z1b = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("s0_settle_bus_a", zbus_a, 32'd10);
        chk("s0_settle_bus_b", zbus_b, 32'd20);
        chk("s0_settle_busy", 32'(zbsy), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (zrsp1) got = 1'b1;
            else @(negedge clk);
        end
        chk("s0_latency", 32'(cyc - t0), 32'd2);
        chk("s0_result", zres, 32'd30);
        chk("s0_resp0_quiet", 32'(zrsp0), 32'd0);
        chk("s0_bus_hold", zbus_a, 32'd10);
        @(negedge clk);
        chk("s0_pulse_one_cycle", 32'(zrsp1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
